regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 SHALL: DEPTH, 4, number of write-queue entries; fixed, not overridable.
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL: in_valid  input  1  write request valid.
REQ-005 SHALL: in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL: in_rd  input  3  destination register index.
REQ-007 SHALL: in_data  input  8  value to write (ALU result).
REQ-008 SHALL: wb_hold  input  1  when high, the queue does not drain.
REQ-009 SHALL: r1, r2  input  3 each  read register indices.
REQ-010 SHALL: d1, d2  output  8 each  read data for r1 and r2.
REQ-011 SHALL: count  output  3  number of pending queue entries, 0..4.

Function
REQ-012 SHALL: the block holds an 8x8 register array and a 4-entry in-order write queue; each entry holds {rd[2:0], data[7:0]}.
REQ-013 SHALL: in_ready = !rst && (count != 4); no push is accepted while full, even if a pop occurs in the same cycle.
REQ-014 SHALL: a push occurs on an edge where in_valid && in_ready; the entry goes to the queue tail.
REQ-015 SHALL: a pop occurs on an edge where count > 0 && !wb_hold; the head entry's data is written to regs[head.rd] on that edge.
REQ-016 SHALL: latency: an entry pushed at edge N is committed to the array no earlier than edge N+1; with an empty queue and wb_hold low, commit is exactly at edge N+1.
REQ-017 SHALL: push and pop on the same edge leave count unchanged; push only increments count; pop only decrements it.
REQ-018 SHALL: head and tail pointers are 2 bits and wrap 3 -> 0; count distinguishes full from empty.
REQ-019 SHALL: entries commit strictly in push order; multiple entries to one register leave the youngest value in the array.
REQ-020 SHALL: d1 and d2 are combinational.
REQ-021 SHALL: d1 returns the data of the youngest valid queue entry whose rd equals r1, else regs[r1]; d2 behaves the same for r2.
REQ-022 SHALL: in_data/in_rd presented in the current cycle are not bypassed to d1/d2; visibility begins after the push edge.
REQ-023 SHALL: no register is hardwired; index 0 is writable.
REQ-024 SHALL: in_valid while in_ready is low is ignored, and no state changes.
REQ-025 SHALL: wb_hold does not block pushes while count < 4.

Reset
REQ-026 SHALL: on an edge with rst high: count=0, pointers=0, all queue entries invalid, and the registers load regs[0]=10, regs[1]=5, regs[2]=3, regs[3]=7, regs[4..7]=0.
REQ-027 SHALL: reset mid-operation discards pending entries without committing them; a push or pop coincident with rst is dropped.
REQ-028 SHALL: in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-029 SHALL: reset, then r1=0, r2=3 -> d1=10, d2=7, count=0, in_ready=1.
REQ-030 SHALL: empty queue, wb_hold=0, push rd=5 data=0x2A at edge N -> after edge N: d1(r1=5)=0x2A, count=1; after edge N+1: regs[5]=0x2A, count=0.
REQ-031 SHALL: wb_hold=1, push 4 entries rd=4..7 -> count=4 and in_ready=0; a 5th in_valid is ignored; wb_hold=0 -> count goes 3, 2, 1, 0 on successive edges, and regs[4..7] hold the pushed values.
REQ-032 SHALL: wb_hold=1, push rd=2 data=0x11 then rd=2 data=0x22 -> d1(r1=2)=0x22 while both entries are pending; after draining, regs[2]=0x22.
REQ-033 SHALL: count=2, wb_hold=0, push on the same edge -> count stays 2, and the committed value matches the head entry.
REQ-034 SHALL: count=3 with pending rd=0 data=0xFF, assert rst for one edge -> count=0, d1(r1=0)=10, and 0xFF never appears in the array.

Source files
------------

// File: rtl/regfile_writer_if.sv
// Request, hold and read-port signals of the queued register-file writer.
interface regfile_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_rd;
  logic [7:0] in_data;
  logic       wb_hold;
  logic [2:0] r1;
  logic [2:0] r2;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [2:0] count;

  modport master (
    output in_valid, in_rd, in_data, wb_hold, r1, r2,
    input  in_ready, d1, d2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, wb_hold, r1, r2,
    output in_ready, d1, d2, count
  );
endinterface

// File: rtl/regfile_writer.sv
// 8x8 register file fed through a 4-entry in-order write queue; reads see the youngest
// pending write to the same register before it reaches the array.
module regfile_writer (
  input  logic            clk,
  input  logic            rst,
  regfile_writer_if.slave bus
);
  localparam int unsigned Depth = 4;

  logic [2:0] q_rd_q   [Depth];
  logic [7:0] q_data_q [Depth];
  logic [7:0] regs_q   [8];
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;
  logic       push, pop;

  function automatic logic [7:0] reset_val(int unsigned idx);
    case (idx)
      0:       return 8'd10;
      1:       return 8'd5;
      2:       return 8'd3;
      3:       return 8'd7;
      default: return 8'd0;
    endcase
  endfunction

  // Readiness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign bus.in_ready = !rst && (count_q != 3'(Depth));
  assign bus.count    = count_q;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count_q != 3'd0) && !bus.wb_hold;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 2'd1;
    if (pop)  head_d = head_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    bus.d1 = regs_q[bus.r1];
    bus.d2 = regs_q[bus.r2];
    for (int i = 0; i < Depth; i++) begin
      if (3'(i) < count_q) begin
        if (q_rd_q[head_q + 2'(i)] == bus.r1) bus.d1 = q_data_q[head_q + 2'(i)];
        if (q_rd_q[head_q + 2'(i)] == bus.r2) bus.d2 = q_data_q[head_q + 2'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      for (int i = 0; i < 8; i++) regs_q[i] <= reset_val(i);
      for (int i = 0; i < Depth; i++) begin
        q_rd_q[i]   <= 3'd0;
        q_data_q[i] <= 8'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        q_rd_q[tail_q]   <= bus.in_rd;
        q_data_q[tail_q] <= bus.in_data;
      end
      if (pop) regs_q[q_rd_q[head_q]] <= q_data_q[head_q];
    end
  end
endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: reset values, bypass, hold/full, ordering, reset flush.
module tb_regfile_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  regfile_writer_if bus ();

  regfile_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [2:0] rd, input logic [7:0] data);
    bus.in_valid = 1'b1;
    bus.in_rd    = rd;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_rd    = 3'd0;
    bus.in_data  = 8'd0;
    bus.wb_hold  = 1'b0;
    bus.r1       = 3'd0;
    bus.r2       = 3'd3;

    // Reset
    step();
    #1;
    check("ready_in_rst", 8'(bus.in_ready), 8'd0);
    check("count_in_rst", 8'(bus.count), 8'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 8'(bus.in_ready), 8'd1);
    check("d1_r0_reset", bus.d1, 8'd10);
    check("d2_r3_reset", bus.d2, 8'd7);
    bus.r1 = 3'd1; bus.r2 = 3'd2;
    #1;
    check("d1_r1_reset", bus.d1, 8'd5);
    check("d2_r2_reset", bus.d2, 8'd3);

    // Single push: no same-cycle bypass, visible after edge, committed next edge
    bus.r1 = 3'd5; bus.r2 = 3'd5;
    bus.in_valid = 1'b1; bus.in_rd = 3'd5; bus.in_data = 8'h2A;
    #1;
    check("no_comb_bypass", bus.d1, 8'h00);
    step();
    bus.in_valid = 1'b0;
    check("bypass_d1_r5", bus.d1, 8'h2A);
    check("count_one", 8'(bus.count), 8'd1);
    step();
    check("count_drained", 8'(bus.count), 8'd0);
    check("regs5_commit", bus.d2, 8'h2A);

    // Fill under hold, overflow push ignored, then drain
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(3'(4 + i), 8'(8'h40 + i));
      check($sformatf("count_fill%0d", i), 8'(bus.count), 8'(i + 1));
    end
    check("ready_full", 8'(bus.in_ready), 8'd0);
    bus.r1 = 3'd0;
    push(3'd0, 8'h99);
    check("count_full_hold", 8'(bus.count), 8'd4);
    check("overflow_ignored", bus.d1, 8'd10);
    bus.wb_hold = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      step();
      check($sformatf("count_drain%0d", i), 8'(bus.count), 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      bus.r1 = 3'(4 + i);
      #1;
      check($sformatf("regs%0d_fill", 4 + i), bus.d1, 8'(8'h40 + i));
    end

    // Two writes to one register: youngest wins in bypass and array
    bus.wb_hold = 1'b1;
    bus.r1 = 3'd2; bus.r2 = 3'd2;
    push(3'd2, 8'h11);
    check("bypass_first_r2", bus.d1, 8'h11);
    push(3'd2, 8'h22);
    check("bypass_young_d1", bus.d1, 8'h22);
    check("bypass_young_d2", bus.d2, 8'h22);
    bus.wb_hold = 1'b0;
    step();
    check("mid_drain_r2", bus.d1, 8'h22);
    step();
    check("count_r2_drain", 8'(bus.count), 8'd0);
    check("regs2_young", bus.d1, 8'h22);

    // Simultaneous push and pop at count=2
    bus.wb_hold = 1'b1;
    push(3'd1, 8'h55);
    push(3'd3, 8'h66);
    check("count_two", 8'(bus.count), 8'd2);
    bus.wb_hold = 1'b0;
    bus.wb_hold = 1'b0;
    bus.in_valid = 1'b1; bus.in_rd = 3'd6; bus.in_data = 8'h77;
    step();
    bus.in_valid = 1'b0;
    bus.wb_hold = 1'b1;
    check("count_pushpop", 8'(bus.count), 8'd2);
    bus.r1 = 3'd1; bus.r2 = 3'd6;
    #1;
    check("head_committed", bus.d1, 8'h55);
    check("bypass_r6", bus.d2, 8'h77);
    bus.wb_hold = 1'b0;
    step();
    step();
    check("count_pp_drain", 8'(bus.count), 8'd0);
    bus.r1 = 3'd3;
    #1;
    check("regs3_commit", bus.d1, 8'h66);
    check("regs6_commit", bus.d2, 8'h77);

    // Reset with pending entries and a coincident push
    bus.wb_hold = 1'b1;
    bus.r1 = 3'd0; bus.r2 = 3'd7;
    push(3'd0, 8'hFF);
    push(3'd7, 8'h01);
    push(3'd4, 8'h02);
    check("count_three", 8'(bus.count), 8'd3);
    check("bypass_ff", bus.d1, 8'hFF);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_rd = 3'd0; bus.in_data = 8'hEE;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.wb_hold = 1'b0;
    #1;
    check("count_flushed", 8'(bus.count), 8'd0);
    check("regs0_flushed", bus.d1, 8'd10);
    check("regs7_flushed", bus.d2, 8'd0);
    step();
    step();
    check("count_stays_zero", 8'(bus.count), 8'd0);
    check("no_ff_commit", bus.d1, 8'd10);

    // Register 0 is writable
    push(3'd0, 8'hAB);
    step();
    check("regs0_write", bus.d1, 8'hAB);
    check("count_final", 8'(bus.count), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
